// File: rtl/gng_pipe_accum_adder.sv
// rtl/gng_pipe_accum_adder.sv - two-stage signed pair adder with optional ACC_N-sample accumulation
module gng_pipe_accum_adder #(
    parameter int A_W   = 18,
    parameter int B_W   = 21,
    parameter int ACC_N = 4,
    parameter int OUT_W = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [A_W-1:0]            dataa,
    input  logic [B_W-1:0]            datab,
    input  logic                      mode,
    input  logic                      clear,
    output logic                      out_valid,
    output logic [OUT_W-1:0]          sum,
    output logic [$clog2(ACC_N):0]    acc_cnt
);

    localparam int CNT_W = $clog2(ACC_N) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_N - 1);

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;

    logic [OUT_W-1:0] s1_q, s1_d;
    logic             s1_v_q, s1_v_d;
    logic             s1_mode_q, s1_mode_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] sum_q, sum_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] acc_plus;

    assign a_ext    = {{(OUT_W-A_W){dataa[A_W-1]}}, dataa};
    assign b_ext    = {{(OUT_W-B_W){datab[B_W-1]}}, datab};
    assign acc_plus = acc_q + s1_q;

    always_comb begin
        s1_d        = s1_q;
        s1_v_d      = 1'b0;
        s1_mode_d   = s1_mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_valid_d = 1'b0;

        // clear drops both the sample in stage 1 and the one arriving now
        if (in_valid && !clear) begin
            s1_d      = a_ext + b_ext;
            s1_mode_d = mode;
            s1_v_d    = 1'b1;
        end

        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (s1_v_q) begin
            if (!s1_mode_q) begin
                sum_d       = s1_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else if (cnt_q == LAST_CNT) begin
                sum_d       = acc_plus;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_plus;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s1_v_q      <= 1'b0;
            s1_mode_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_v_q      <= s1_v_d;
            s1_mode_q   <= s1_mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_gng_pipe_accum_adder.sv
// tb/tb_gng_pipe_accum_adder.sv - directed self-checking bench for gng_pipe_accum_adder
module tb_gng_pipe_accum_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [17:0] dataa;
    logic [20:0] datab;
    logic        mode;
    logic        clear;
    logic        out_valid;
    logic [23:0] sum;
    logic [2:0]  acc_cnt;

    int errors = 0;
    int checks = 0;
    int ov_cnt = 0;
    logic [23:0] last_sum = '0;
    int base;

    gng_pipe_accum_adder #(
        .A_W(18), .B_W(21), .ACC_N(4), .OUT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dataa(dataa), .datab(datab),
        .mode(mode), .clear(clear), .out_valid(out_valid), .sum(sum), .acc_cnt(acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (out_valid) begin
            ov_cnt   = ov_cnt + 1;
            last_sum = sum;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [17:0] a, input logic [20:0] b, input logic m);
        dataa    = a;
        datab    = b;
        mode     = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; dataa = '0; datab = '0; mode = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_sum", 32'(sum), 32'd0);
        check_eq("reset_acc_cnt", 32'(acc_cnt), 32'd0);
        rst = 1'b0;

        // Mode 0: -1 + 1 cancels
        send(18'h3FFFF, 21'h000001, 1'b0);
        check_eq("m0_cancel_lat1_ov", 32'(out_valid), 32'd0);
        step();
        check_eq("m0_cancel_ov", 32'(out_valid), 32'd1);
        check_eq("m0_cancel_sum", 32'(sum), 32'h000000);
        step();
        check_eq("m0_cancel_ov_drop", 32'(out_valid), 32'd0);

        // Mode 0 extremes, back to back
        send(18'h1FFFF, 21'h0FFFFF, 1'b0);
        send(18'h20000, 21'h100000, 1'b0);
        check_eq("m0_maxpos_ov", 32'(out_valid), 32'd1);
        check_eq("m0_maxpos_sum", 32'(sum), 32'h11FFFE);
        step();
        check_eq("m0_maxneg_ov", 32'(out_valid), 32'd1);
        check_eq("m0_maxneg_sum", 32'(sum), 32'hEE0000);
        step();
        check_eq("m0_hold_ov", 32'(out_valid), 32'd0);
        check_eq("m0_hold_sum", 32'(sum), 32'hEE0000);

        // Mode 1: four most-negative samples back to back
        for (int i = 0; i < 4; i++) begin
            send(18'h20000, 21'h100000, 1'b1);
            check_eq($sformatf("m1_neg_ov_%0d", i), 32'(out_valid), 32'd0);
            check_eq($sformatf("m1_neg_cnt_%0d", i), 32'(acc_cnt), 32'(i));
        end
        step();
        check_eq("m1_neg_ov", 32'(out_valid), 32'd1);
        check_eq("m1_neg_sum", 32'(sum), 32'hB80000);
        check_eq("m1_neg_cnt_wrap", 32'(acc_cnt), 32'd0);
        step();
        check_eq("m1_neg_ov_drop", 32'(out_valid), 32'd0);

        // Mode 1 with bubbles of 0..3 idle cycles
        base = ov_cnt;
        for (int i = 0; i < 4; i++) begin
            send(18'(i + 1), 21'(i + 1), 1'b1);
            idle(i);
        end
        idle(3);
        check_eq("m1_bubble_pulses", 32'(ov_cnt - base), 32'd1);
        check_eq("m1_bubble_sum", 32'(last_sum), 32'd20);

        // Mode switch 1 -> 0 drops partial sum
        base = ov_cnt;
        send(18'd1, 21'd1, 1'b1);
        send(18'd1, 21'd1, 1'b1);
        send(18'd5, 21'h1FFFFE, 1'b0);
        idle(2);
        check_eq("switch_pulses", 32'(ov_cnt - base), 32'd1);
        check_eq("switch_sum", 32'(last_sum), 32'd3);
        check_eq("switch_cnt", 32'(acc_cnt), 32'd0);

        // Then 0 -> 1 starts a fresh block
        base = ov_cnt;
        for (int i = 0; i < 4; i++) send(18'd1, 21'd0, 1'b1);
        idle(2);
        check_eq("fresh_pulses", 32'(ov_cnt - base), 32'd1);
        check_eq("fresh_sum", 32'(last_sum), 32'd4);

        // clear after 3 samples, with the 3rd still in stage 1
        base = ov_cnt;
        for (int i = 0; i < 3; i++) send(18'd1, 21'd1, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        idle(3);
        check_eq("clear_pulses", 32'(ov_cnt - base), 32'd0);
        check_eq("clear_cnt", 32'(acc_cnt), 32'd0);
        check_eq("clear_sum_hold", 32'(sum), 32'd4);
        base = ov_cnt;
        for (int i = 0; i < 4; i++) send(18'd2, 21'd1, 1'b1);
        idle(2);
        check_eq("post_clear_pulses", 32'(ov_cnt - base), 32'd1);
        check_eq("post_clear_sum", 32'(last_sum), 32'd12);

        // Asynchronous reset mid-block
        send(18'd1, 21'd1, 1'b1);
        send(18'd1, 21'd1, 1'b1);
        idle(1);
        check_eq("pre_rst_cnt", 32'(acc_cnt), 32'd2);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_ov", 32'(out_valid), 32'd0);
        check_eq("async_rst_sum", 32'(sum), 32'd0);
        check_eq("async_rst_cnt", 32'(acc_cnt), 32'd0);
        #1 rst = 1'b0;
        step();
        base = ov_cnt;
        for (int i = 0; i < 4; i++) send(18'd1, 21'd1, 1'b1);
        idle(2);
        check_eq("post_rst_pulses", 32'(ov_cnt - base), 32'd1);
        check_eq("post_rst_sum", 32'(last_sum), 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gng_pipe_accum_adder.md
Name: gng_pipe_accum_adder

Overview:
- Parametrised, pipelined successor to the GNG two-operand signed adder: adds a signed dataa to a signed datab each valid cycle.
- Mode 0 outputs every sum. Mode 1 accumulates ACC_N consecutive sums into one output, the central-limit summation step of the Gaussian noise generator.
- Sits between the uniform/partial-sum stages and the noise output register; streaming, no backpressure.

Parameters:
- A_W, 18, width of signed dataa (two's complement).
- B_W, 21, width of signed datab (two's complement).
- ACC_N, 4, number of pair-sums combined per output in mode 1; legal range 2..256.
- OUT_W, 24, sum width. Must be >= max(A_W,B_W)+1+clog2(ACC_N); with this width no overflow is possible.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dataa/datab/mode are valid this cycle.
- dataa  input  A_W  signed operand A.
- datab  input  B_W  signed operand B.
- mode  input  1  0 = per-sample add; 1 = accumulate ACC_N samples. Sampled with in_valid.
- clear  input  1  synchronous flush of the accumulation state.
- out_valid  output  1  one-cycle strobe: sum is new.
- sum  output  OUT_W  signed result, registered.
- acc_cnt  output  clog2(ACC_N)+1  number of samples held in the partial accumulation.

Behaviour:
- Reset (async, rst=1): out_valid=0, sum=0, acc_cnt=0; stage-1 register, stage-1 valid, stage-1 mode and accumulator all 0. Holds while rst=1. Deasserting rst mid-accumulation starts from an empty state.
- Stage 1, on a clock edge with in_valid=1:
  - s1 <= sext(dataa, OUT_W) + sext(datab, OUT_W), where sext is sign extension.
  - s1_mode <= mode; s1_v <= 1.
  - Otherwise s1_v <= 0.
- Stage 2 when s1_v=1 and mode 0 (s1_mode=0):
  - sum <= s1; out_valid <= 1.
  - Any partial accumulation is discarded: acc <= 0, acc_cnt <= 0.
- Stage 2 when s1_v=1 and mode 1 (s1_mode=1):
  - If acc_cnt < ACC_N-1: acc <= acc + s1; acc_cnt++; out_valid <= 0.
  - If acc_cnt == ACC_N-1: sum <= acc + s1; out_valid <= 1; acc <= 0; acc_cnt <= 0.
- Stage 2 when s1_v=0: out_valid <= 0; acc, acc_cnt and sum hold.
- Latency: inputs presented in cycle 0 give out_valid/sum in cycle 2 (mode 0), or cycle 2 after the ACC_N-th valid sample (mode 1).
- Throughput: one sample per cycle. in_valid gaps (bubbles) are legal and do not break the accumulation.
- sum holds its last value while out_valid=0.
- Mode switch:
  - 1→0 mid-block: partial sum dropped without output; the mode-0 sample is output normally.
  - 0→1: accumulation starts at count 0.
- clear=1: on that edge acc <= 0, acc_cnt <= 0, s1_v <= 0, out_valid <= 0.
  - The in-flight stage-1 sample and any sample presented the same cycle are discarded.
  - sum holds.
- Arithmetic: full-precision two's complement, no saturation, no rounding.

Test Plan:
- Mode 0 cancel: rst pulse; dataa=18'h3FFFF (-1), datab=21'h000001 (+1), in_valid one cycle → cycle 2 out_valid=1, sum=24'h000000; cycle 3 out_valid=0, sum holds.
- Mode 0 max positive: dataa=18'h1FFFF, datab=21'h0FFFFF → sum=24'h11FFFE (1179646).
  - Back-to-back next sample dataa=18'h20000, datab=21'h100000 → next cycle sum=24'hEE0000 (-1179648); out_valid high 2 consecutive cycles.
- Mode 1 ACC_N=4 most negative: four consecutive samples dataa=18'h20000, datab=21'h100000 → out_valid only in the cycle 2 after the 4th sample, sum=24'hB80000 (-4718592). acc_cnt shows 1,2,3,0.
- Mode 1 with bubbles: samples (1,1),(2,2),(3,3),(4,4) separated by 0–3 idle cycles → single output sum=20; no out_valid elsewhere.
- Flush cases:
  - Two mode-1 samples, then mode-0 sample (5,-2) → sum=3 out_valid=1, acc_cnt=0; a following 4-sample mode-1 block of (1,0) gives sum=4.
  - clear asserted after 3 mode-1 samples → no output; acc_cnt=0.
- Async reset mid-block: after 2 mode-1 samples, assert rst between clock edges → out_valid=0, sum=0, acc_cnt=0 immediately (before next edge). After release, 4 samples of (1,1) → sum=8.
